// File: rtl/fsb_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsb_axil_pkg
// Description : Register offsets, FSB packet width, adapter state encoding and
//               the packet-to-word mapping shared by both ends of the OCL link.
// Revision    : 1.0 - initial release
// ============================================================================
package fsb_axil_pkg;

    localparam int FSB_W = 80;

    localparam logic [31:0] c_tdfd_off  = 32'h0000_0010;
    localparam logic [31:0] c_tlr_off   = 32'h0000_0014;
    localparam logic [31:0] c_rdfo_off  = 32'h0000_001C;
    localparam logic [31:0] c_rdfd_off  = 32'h0000_0020;
    localparam logic [31:0] c_rlr_off   = 32'h0000_0024;
    localparam logic [31:0] c_pkt_bytes = 32'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX_WR  = 3'd1,
        ST_TX_LEN = 3'd2,
        ST_POLL   = 3'd3,
        ST_RLEN   = 3'd4,
        ST_RX_RD  = 3'd5,
        ST_RX_OUT = 3'd6,
        ST_DRAIN  = 3'd7
    } fsb_state_e;

    // Word k of a packet as it sits in the FIFO; word 3 is padding.
    function automatic logic [31:0] fsb_word(input logic [FSB_W-1:0] d, input logic [1:0] k);
        logic [31:0] w;
        w = 32'h0;
        case (k)
            2'd0:    w = d[31:0];
            2'd1:    w = d[63:32];
            2'd2:    w = {16'h0, d[79:64]};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_master_single_op.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_single_op
// Description : AXI-lite master issuing one read or write at a time; a new op
//               may be started in the same cycle the previous one completes.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master_single_op (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  resp,
    output logic [31:0] m_awaddr_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    input  logic [1:0]  m_bresp_i,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    output logic [31:0] m_araddr_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rvalid_i,
    output logic        m_rready_o
);

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic        w_b_hs;
    logic        w_r_hs;

    assign w_b_hs = r_bready & m_bvalid_i;
    assign w_r_hs = r_rready & m_rvalid_i;
    assign done   = w_b_hs | w_r_hs;
    assign rdata  = m_rdata_i;
    assign resp   = w_b_hs ? m_bresp_i : m_rresp_i;

    // Later assignments win, so a start in the completion cycle re-arms cleanly.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            if (m_awready_i) r_awvalid <= 1'b0;
            if (m_wready_i)  r_wvalid  <= 1'b0;
            if (w_b_hs)      r_bready  <= 1'b0;
            if (r_arvalid && m_arready_i) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end
            if (w_r_hs)      r_rready  <= 1'b0;
            if (start) begin
                r_addr <= addr;
                if (we) begin
                    r_wdata   <= wdata;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_bready  <= 1'b1;
                end else begin
                    r_arvalid <= 1'b1;
                end
            end
        end
    end

    assign m_awaddr_o  = r_addr;
    assign m_araddr_o  = r_addr;
    assign m_awvalid_o = r_awvalid;
    assign m_wdata_o   = r_wdata;
    assign m_wstrb_o   = 4'hF;
    assign m_wvalid_o  = r_wvalid;
    assign m_bready_o  = r_bready;
    assign m_arvalid_o = r_arvalid;
    assign m_rready_o  = r_rready;

endmodule
`default_nettype wire

// File: rtl/m_axil_fsb_adapter.sv
`default_nettype none
// ============================================================================
// Module      : m_axil_fsb_adapter
// Description : AXI-lite initiator for the FSB FIFO bridge: packs FSB packets
//               into TX FIFO writes and polls/unpacks RX FIFO reads.
// Revision    : 1.0 - initial release
// ============================================================================
module m_axil_fsb_adapter
    import fsb_axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_GAP  = 16
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             tx_v_i,
    input  logic [FSB_W-1:0] tx_data_i,
    output logic             tx_ready_o,
    output logic             rx_v_o,
    output logic [FSB_W-1:0] rx_data_o,
    input  logic             rx_ready_i,
    output logic [31:0]      m_awaddr_o,
    output logic             m_awvalid_o,
    input  logic             m_awready_i,
    output logic [31:0]      m_wdata_o,
    output logic [3:0]       m_wstrb_o,
    output logic             m_wvalid_o,
    input  logic             m_wready_i,
    input  logic [1:0]       m_bresp_i,
    input  logic             m_bvalid_i,
    output logic             m_bready_o,
    output logic [31:0]      m_araddr_o,
    output logic             m_arvalid_o,
    input  logic             m_arready_i,
    input  logic [31:0]      m_rdata_i,
    input  logic [1:0]       m_rresp_i,
    input  logic             m_rvalid_i,
    output logic             m_rready_o,
    output logic             err_o
);

    localparam logic [15:0] c_poll_gap = 16'(POLL_GAP);

    fsb_state_e       r_state, w_state_nxt;
    logic [29:0]      r_cnt, w_cnt_nxt;
    logic [15:0]      r_timer;
    logic             r_live;
    logic             r_err;
    logic [FSB_W-1:0] r_tx_data;
    logic [FSB_W-1:0] r_rx_data;
    logic             w_expired;
    logic             w_start, w_we, w_done;
    logic [31:0]      w_addr, w_wdata, w_rdata;
    logic [1:0]       w_resp;

    assign w_expired  = (r_timer == c_poll_gap);
    // r_live keeps tx_ready_o low through reset and the first edge after it.
    assign tx_ready_o = r_live && (r_state == ST_IDLE) && !w_expired;
    assign rx_v_o     = (r_state == ST_RX_OUT);
    assign rx_data_o  = r_rx_data;
    assign err_o      = r_err;

    // Each op is launched on the transition that needs it, so start only
    // fires while the op engine is idle or completing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_we        = 1'b0;
        w_addr      = 32'h0;
        w_wdata     = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (r_live && w_expired) begin
                    w_start = 1'b1;
                    w_addr  = BASE_ADDR + c_rdfo_off;
                    w_state_nxt = ST_POLL;
                end else if (tx_ready_o && tx_v_i) begin
                    w_start = 1'b1;
                    w_we    = 1'b1;
                    w_addr  = BASE_ADDR + c_tdfd_off;
                    w_wdata = fsb_word(tx_data_i, 2'd0);
                    w_cnt_nxt   = 30'd0;
                    w_state_nxt = ST_TX_WR;
                end
            end
            ST_TX_WR: begin
                if (w_done) begin
                    w_start = 1'b1;
                    w_we    = 1'b1;
                    if (r_cnt[1:0] == 2'd3) begin
                        w_addr  = BASE_ADDR + c_tlr_off;
                        w_wdata = c_pkt_bytes;
                        w_state_nxt = ST_TX_LEN;
                    end else begin
                        w_addr  = BASE_ADDR + c_tdfd_off;
                        w_wdata = fsb_word(r_tx_data, r_cnt[1:0] + 2'd1);
                        w_cnt_nxt = r_cnt + 30'd1;
                    end
                end
            end
            ST_TX_LEN: begin
                if (w_done) w_state_nxt = ST_IDLE;
            end
            ST_POLL: begin
                if (w_done) begin
                    if (w_rdata < 32'd4) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_start = 1'b1;
                        w_addr  = BASE_ADDR + c_rlr_off;
                        w_state_nxt = ST_RLEN;
                    end
                end
            end
            ST_RLEN: begin
                if (w_done) begin
                    w_addr = BASE_ADDR + c_rdfd_off;
                    if (w_rdata == c_pkt_bytes) begin
                        w_start     = 1'b1;
                        w_cnt_nxt   = 30'd0;
                        w_state_nxt = ST_RX_RD;
                    end else if (w_rdata[31:2] == 30'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_start     = 1'b1;
                        w_cnt_nxt   = w_rdata[31:2] - 30'd1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_RX_RD: begin
                if (w_done) begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_state_nxt = ST_RX_OUT;
                    end else begin
                        w_start   = 1'b1;
                        w_addr    = BASE_ADDR + c_rdfd_off;
                        w_cnt_nxt = r_cnt + 30'd1;
                    end
                end
            end
            ST_RX_OUT: begin
                if (rx_ready_i) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (w_done) begin
                    if (r_cnt == 30'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_start   = 1'b1;
                        w_addr    = BASE_ADDR + c_rdfd_off;
                        w_cnt_nxt = r_cnt - 30'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 30'd0;
            r_timer   <= 16'd0;
            r_live    <= 1'b0;
            r_err     <= 1'b0;
            r_tx_data <= '0;
            r_rx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_live  <= 1'b1;
            if (r_live && r_state == ST_IDLE)
                r_timer <= w_expired ? 16'd0 : r_timer + 16'd1;
            if (tx_ready_o && tx_v_i)
                r_tx_data <= tx_data_i;
            if (w_done && w_resp != 2'b00)
                r_err <= 1'b1;
            if (r_state == ST_RLEN && w_done && w_rdata != c_pkt_bytes)
                r_err <= 1'b1;
            if (r_state == ST_RX_RD && w_done) begin
                case (r_cnt[1:0])
                    2'd0:    r_rx_data[31:0]  <= w_rdata;
                    2'd1:    r_rx_data[63:32] <= w_rdata;
                    2'd2:    r_rx_data[79:64] <= w_rdata[15:0];
                    default: ;
                endcase
            end
        end
    end

    axil_master_single_op u_op (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .start       (w_start),
        .we          (w_we),
        .addr        (w_addr),
        .wdata       (w_wdata),
        .done        (w_done),
        .rdata       (w_rdata),
        .resp        (w_resp),
        .m_awaddr_o  (m_awaddr_o),
        .m_awvalid_o (m_awvalid_o),
        .m_awready_i (m_awready_i),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_wvalid_o  (m_wvalid_o),
        .m_wready_i  (m_wready_i),
        .m_bresp_i   (m_bresp_i),
        .m_bvalid_i  (m_bvalid_i),
        .m_bready_o  (m_bready_o),
        .m_araddr_o  (m_araddr_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .m_rdata_i   (m_rdata_i),
        .m_rresp_i   (m_rresp_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rready_o  (m_rready_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_m_axil_fsb_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_axil_fsb_adapter
// Description : Directed bench for m_axil_fsb_adapter with a reactive FIFO-bridge
//               slave model driven on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_axil_fsb_adapter;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tx_v = 1'b0;
    logic [79:0] tx_data = '0;
    logic        tx_ready;
    logic        rx_v;
    logic [79:0] rx_data;
    logic        rx_ready = 1'b0;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;
    logic        err;

    always #5 clk = ~clk;

    m_axil_fsb_adapter #(.BASE_ADDR(BASE), .POLL_GAP(4)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .tx_v_i(tx_v), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
        .rx_v_o(rx_v), .rx_data_o(rx_data), .rx_ready_i(rx_ready),
        .m_awaddr_o(awaddr), .m_awvalid_o(awvalid), .m_awready_i(awready),
        .m_wdata_o(wdata), .m_wstrb_o(wstrb), .m_wvalid_o(wvalid), .m_wready_i(wready),
        .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready),
        .m_araddr_o(araddr), .m_arvalid_o(arvalid), .m_arready_i(arready),
        .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rvalid_i(rvalid), .m_rready_o(rready),
        .err_o(err)
    );

    int n_pass = 0;
    int n_total = 0;

    // Slave configuration and observation
    logic [63:0] wr_log[$];
    logic [31:0] rx_q[$];
    logic [31:0] rdfo_val = 32'h0;
    logic [31:0] rlr_val = 32'd16;
    int  aw_dly = 0, w_dly = 0, wr_total = 0, err_idx = -1, n_rdfd = 0;
    bit  rand_resp = 1'b0, rx_v_seen = 1'b0, axi_in_rxout = 1'b0;

    // Slave internal state
    bit  f_aw, f_w, f_b, f_ar, f_r, got_aw, got_w, b_pend, ar_pend;
    logic [31:0] f_awaddr, f_wdata, f_araddr, a_addr, w_dat, rd_word;
    logic [1:0]  b_code;
    int  aw_ctr, w_ctr, b_wait, r_wait;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
                got_aw = 0; got_w = 0; b_pend = 0; ar_pend = 0;
                aw_ctr = 0; w_ctr = 0; b_wait = 0; r_wait = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                bresp = 2'b00;
            end else begin
                if (f_aw) begin got_aw = 1; a_addr = f_awaddr; awready = 0; end
                if (f_w)  begin got_w = 1;  w_dat = f_wdata;   wready = 0; end
                if (f_b)  bvalid = 0;
                if (f_r)  rvalid = 0;
                if (f_ar) begin
                    arready = 0;
                    ar_pend = 1;
                    r_wait = rand_resp ? int'($urandom_range(0, 3)) : 0;
                    case (f_araddr - BASE)
                        32'h1C: rd_word = rdfo_val;
                        32'h24: begin rd_word = rlr_val; rdfo_val = 32'h0; end
                        32'h20: begin
                            n_rdfd++;
                            rd_word = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
                        end
                        default: rd_word = 32'h0;
                    endcase
                end
                if (got_aw && got_w) begin
                    wr_log.push_back({a_addr, w_dat});
                    b_code = (wr_total == err_idx) ? 2'b10 : 2'b00;
                    wr_total++;
                    got_aw = 0; got_w = 0; b_pend = 1;
                    b_wait = rand_resp ? int'($urandom_range(0, 3)) : 0;
                end
                if (awvalid && !awready && !got_aw) begin
                    if (aw_ctr >= aw_dly) begin awready = 1; aw_ctr = 0; end else aw_ctr++;
                end
                if (wvalid && !wready && !got_w) begin
                    if (w_ctr >= w_dly) begin wready = 1; w_ctr = 0; end else w_ctr++;
                end
                if (b_pend && !bvalid) begin
                    if (b_wait == 0) begin bvalid = 1; bresp = b_code; b_pend = 0; end else b_wait--;
                end
                if (arvalid && !arready && !ar_pend) arready = 1;
                if (ar_pend && !rvalid) begin
                    if (r_wait == 0) begin rvalid = 1; rdata = rd_word; ar_pend = 0; end else r_wait--;
                end
                f_aw = awvalid && awready; f_awaddr = awaddr;
                f_w  = wvalid && wready;   f_wdata  = wdata;
                f_b  = bready && bvalid;
                f_ar = arvalid && arready; f_araddr = araddr;
                f_r  = rready && rvalid;
            end
            if (rx_v) rx_v_seen = 1;
            if (rx_v && (arvalid || awvalid)) axi_in_rxout = 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        tx_v = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic send_pkt(input logic [79:0] d, output bit ok);
        ok = 0;
        @(negedge clk);
        tx_v = 1'b1;
        tx_data = d;
        for (int i = 0; i < 300; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                #1 tx_v = 1'b0;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        tx_v = 1'b0;
    endtask

    task automatic wait_writes(input int n, output bit ok);
        for (int i = 0; i < 1000; i++) begin
            if (wr_log.size() >= n) break;
            @(negedge clk);
        end
        ok = (wr_log.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_total++; if ({tx_ready, rx_v, awvalid, wvalid, bready, arvalid, rready, err} !== 8'h00) $display("FAIL reset_ctrl got=%b want=00000000", {tx_ready, rx_v, awvalid, wvalid, bready, arvalid, rready, err}); else n_pass++;
        n_total++; if (awaddr !== 32'h0) $display("FAIL reset_awaddr got=%h want=0", awaddr); else n_pass++;
        n_total++; if (araddr !== 32'h0) $display("FAIL reset_araddr got=%h want=0", araddr); else n_pass++;
        n_total++; if (wdata !== 32'h0) $display("FAIL reset_wdata got=%h want=0", wdata); else n_pass++;
        n_total++; if (rx_data !== 80'h0) $display("FAIL reset_rxdata got=%h want=0", rx_data); else n_pass++;
        n_total++; if (wstrb !== 4'hF) $display("FAIL reset_wstrb got=%h want=f", wstrb); else n_pass++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_idle_ready got=%b want=1", tx_ready); else n_pass++;
    endtask

    task automatic test_tx_zero_wait();
        logic [63:0] exp_w [5];
        int base;
        bit ok;
        exp_w = '{64'h0000_1010_0123_4567, 64'h0000_1010_89AB_CDEF, 64'h0000_1010_0000_1234,
                  64'h0000_1010_0000_0000, 64'h0000_1014_0000_0010};
        base = wr_log.size();
        send_pkt(80'h1234_89ABCDEF_01234567, ok);
        wait_writes(base + 5, ok);
        n_total++; if (!ok) $display("FAIL tx0_timeout got=%0d want=%0d writes", wr_log.size() - base, 5); else n_pass++;
        repeat (30) @(negedge clk);
        n_total++; if (wr_log.size() != base + 5) $display("FAIL tx0_count got=%0d want=5", wr_log.size() - base); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (wr_log.size() <= base + i || wr_log[base + i] !== exp_w[i]) $display("FAIL tx0_word%0d got=%h want=%h", i, (wr_log.size() > base + i) ? wr_log[base + i] : 64'hX, exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rx();
        bit got, held;
        rx_q = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_FFFF, 32'h1357_9BDF};
        rlr_val = 32'd16;
        n_rdfd = 0;
        axi_in_rxout = 0;
        rdfo_val = 32'd4;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_v) begin got = 1; break; end
        end
        n_total++; if (!got) $display("FAIL rx_timeout got=0 want=1 rx_v"); else n_pass++;
        held = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rx_v !== 1'b1) held = 0;
        end
        n_total++; if (!held) $display("FAIL rx_hold got=0 want=1 rx_v held"); else n_pass++;
        n_total++; if (rx_data !== 80'hFFFF_5A5A5A5A_A5A5A5A5) $display("FAIL rx_data got=%h want=%h", rx_data, 80'hFFFF_5A5A5A5A_A5A5A5A5); else n_pass++;
        n_total++; if (axi_in_rxout) $display("FAIL rx_quiet got=1 want=0 ops during rx_v"); else n_pass++;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (rx_v !== 1'b0) $display("FAIL rx_release got=%b want=0", rx_v); else n_pass++;
        rx_ready = 1'b0;
        n_total++; if (n_rdfd != 4) $display("FAIL rx_rdfd_reads got=%0d want=4", n_rdfd); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rx_err got=%b want=0", err); else n_pass++;
    endtask

    task automatic test_bad_len();
        logic [63:0] exp_w [5];
        int base;
        bit got, ok;
        exp_w = '{64'h0000_1010_00BA_DA55, 64'h0000_1010_00C0_FFEE, 64'h0000_1010_0000_7E57,
                  64'h0000_1010_0000_0000, 64'h0000_1014_0000_0010};
        rx_q = '{32'h1111_1111, 32'h2222_2222};
        rlr_val = 32'd8;
        n_rdfd = 0;
        rx_v_seen = 0;
        rdfo_val = 32'd4;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (err) begin got = 1; break; end
        end
        n_total++; if (!got) $display("FAIL badlen_err got=%b want=1", err); else n_pass++;
        repeat (40) @(negedge clk);
        n_total++; if (n_rdfd != 2) $display("FAIL badlen_drain got=%0d want=2", n_rdfd); else n_pass++;
        n_total++; if (rx_v_seen) $display("FAIL badlen_rxv got=1 want=0"); else n_pass++;
        base = wr_log.size();
        send_pkt(80'h7E57_00C0FFEE_00BADA55, ok);
        wait_writes(base + 5, ok);
        repeat (20) @(negedge clk);
        n_total++; if (wr_log.size() != base + 5) $display("FAIL badlen_tx_count got=%0d want=5", wr_log.size() - base); else n_pass++;
        for (int i = 0; i < 5; i += 2) begin
            n_total++;
            if (wr_log.size() <= base + i || wr_log[base + i] !== exp_w[i]) $display("FAIL badlen_tx_word%0d got=%h want=%h", i, (wr_log.size() > base + i) ? wr_log[base + i] : 64'hX, exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_w [10];
        int base;
        bit ok1, ok2, ok;
        exp_w = '{64'h0000_1010_7654_3210, 64'h0000_1010_FEDC_BA98, 64'h0000_1010_0000_ABCD,
                  64'h0000_1010_0000_0000, 64'h0000_1014_0000_0010,
                  64'h0000_1010_3333_4444, 64'h0000_1010_1111_2222, 64'h0000_1010_0000_0F0F,
                  64'h0000_1010_0000_0000, 64'h0000_1014_0000_0010};
        aw_dly = 3; w_dly = 1; rand_resp = 1;
        base = wr_log.size();
        ok1 = 0; ok2 = 0;
        @(negedge clk);
        tx_v = 1'b1;
        tx_data = 80'hABCD_FEDCBA98_76543210;
        for (int i = 0; i < 300; i++) begin
            if (tx_ready) begin @(posedge clk); #1 tx_data = 80'h0F0F_11112222_33334444; ok1 = 1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 300 && ok1; i++) begin
            @(negedge clk);
            if (tx_ready) begin @(posedge clk); #1 ok2 = 1; break; end
        end
        tx_v = 1'b0;
        n_total++; if (!(ok1 && ok2)) $display("FAIL bp_accept got=%b%b want=11", ok1, ok2); else n_pass++;
        wait_writes(base + 10, ok);
        repeat (40) @(negedge clk);
        n_total++; if (wr_log.size() != base + 10) $display("FAIL bp_count got=%0d want=10", wr_log.size() - base); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (wr_log.size() <= base + i || wr_log[base + i] !== exp_w[i]) $display("FAIL bp_word%0d got=%h want=%h", i, (wr_log.size() > base + i) ? wr_log[base + i] : 64'hX, exp_w[i]);
            else n_pass++;
        end
        aw_dly = 0; w_dly = 0; rand_resp = 0;
    endtask

    task automatic test_slverr();
        logic [63:0] exp_w [5];
        int base;
        bit ok;
        exp_w = '{64'h0000_1010_DEAD_C0DE, 64'h0000_1010_CAFE_F00D, 64'h0000_1010_0000_BEEF,
                  64'h0000_1010_0000_0000, 64'h0000_1014_0000_0010};
        do_reset();
        @(negedge clk);
        n_total++; if (err !== 1'b0) $display("FAIL slverr_cleared got=%b want=0", err); else n_pass++;
        base = wr_log.size();
        err_idx = wr_total + 1;
        send_pkt(80'hBEEF_CAFEF00D_DEADC0DE, ok);
        wait_writes(base + 5, ok);
        repeat (20) @(negedge clk);
        err_idx = -1;
        n_total++; if (err !== 1'b1) $display("FAIL slverr_err got=%b want=1", err); else n_pass++;
        n_total++; if (wr_log.size() != base + 5) $display("FAIL slverr_count got=%0d want=5", wr_log.size() - base); else n_pass++;
        for (int i = 1; i < 5; i++) begin
            n_total++;
            if (wr_log.size() <= base + i || wr_log[base + i] !== exp_w[i]) $display("FAIL slverr_word%0d got=%h want=%h", i, (wr_log.size() > base + i) ? wr_log[base + i] : 64'hX, exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [63:0] exp_w [5];
        int base, mid;
        bit ok;
        exp_w = '{64'h0000_1010_0000_0003, 64'h0000_1010_0000_0002, 64'h0000_1010_0000_0001,
                  64'h0000_1010_0000_0000, 64'h0000_1014_0000_0010};
        base = wr_log.size();
        send_pkt(80'h5555_66667777_88889999, ok);
        wait_writes(base + 2, ok);
        n_total++; if (!ok) $display("FAIL rst_mid_w1 got=%0d want=2 writes", wr_log.size() - base); else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++; if ({tx_ready, rx_v, awvalid, wvalid, bready, arvalid, rready, err} !== 8'h00) $display("FAIL rst_mid_ctrl got=%b want=00000000", {tx_ready, rx_v, awvalid, wvalid, bready, arvalid, rready, err}); else n_pass++;
        n_total++; if ({awaddr, wdata} !== 64'h0) $display("FAIL rst_mid_bus got=%h want=0", {awaddr, wdata}); else n_pass++;
        mid = wr_log.size();
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (tx_ready !== 1'b1) $display("FAIL rst_mid_idle got=%b want=1", tx_ready); else n_pass++;
        repeat (10) @(negedge clk);
        n_total++; if (wr_log.size() != mid) $display("FAIL rst_mid_quiet got=%0d want=0 new writes", wr_log.size() - mid); else n_pass++;
        send_pkt(80'h0001_00000002_00000003, ok);
        wait_writes(mid + 5, ok);
        repeat (20) @(negedge clk);
        n_total++; if (wr_log.size() != mid + 5) $display("FAIL rst_mid_count got=%0d want=5", wr_log.size() - mid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (wr_log.size() <= mid + i || wr_log[mid + i] !== exp_w[i]) $display("FAIL rst_mid_word%0d got=%h want=%h", i, (wr_log.size() > mid + i) ? wr_log[mid + i] : 64'hX, exp_w[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_tx_zero_wait();
        test_rx();
        test_back_to_back();
        test_bad_len();
        test_slverr();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
